prod_accum: RTL and testbench

Drain stage sitting directly downstream of the product FIFO in the kadai3 datapath. It pops 16-bit products from the output FIFO's read port (RD/DOUT/EMPTY/VALID), sums each group of BLOCK_LEN products, and presents the block sum on a valid/ready output handshake. Reads are pipelined: a new RD may be issued every cycle while the FIFO is non-empty and the block is not yet fully requested. A data word is accepted only on VALID, whatever the FIFO read latency.

---
 rtl/prod_accum.sv | 102 ++++++++++
 tb/tb_prod_accum.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// prod_accum: drains the product FIFO read port, sums each group of BLOCK_LEN
// products and offers the sum on a valid/ready port. Optional macro: PROD_ACCUM_SAT_EN.
module prod_accum #(
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W     = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EMPTY,
  input  logic             VALID,
  input  logic [15:0]      FIFO_DOUT,
  output logic             RD,
  output logic [ACC_W-1:0] SUM,
  output logic             SUM_VALID,
  input  logic             SUM_READY,
  output logic [15:0]      BLK_CNT,
  output logic             o_state_dbg
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LEN      = 8'(BLOCK_LEN);
  localparam logic [7:0] LAST_IDX = 8'(BLOCK_LEN - 1);

  state_t           r_state;
  logic [7:0]       r_issued;
  logic [7:0]       r_recv;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic             r_sum_valid;
  logic [15:0]      r_blk_cnt;

  logic             w_accept;
  logic             w_last;
  logic [ACC_W:0]   w_add_full;
  logic [ACC_W-1:0] w_add;

  // Reads stop once the whole block is requested; words only count while a read
  // is outstanding, so stray VALIDs and pre-reset in-flight data are dropped.
  assign RD       = RST && (r_state == ACCUM) && !EMPTY && (r_issued < LEN);
  assign w_accept = VALID && (r_state == ACCUM) && (r_recv < r_issued);
  assign w_last   = (r_recv == LAST_IDX);

  assign w_add_full = {1'b0, r_acc} + {{(ACC_W + 1 - 16){1'b0}}, FIFO_DOUT};
`ifdef PROD_ACCUM_SAT_EN
  assign w_add = w_add_full[ACC_W] ? '1 : w_add_full[ACC_W-1:0];
`else
  assign w_add = w_add_full[ACC_W-1:0];
`endif

  // Output handshake: SUM transfers on a rising edge with SUM_VALID && SUM_READY;
  // SUM stays stable while SUM_VALID is high and not yet accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ACCUM;
      r_issued    <= '0;
      r_recv      <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (RD) begin
            r_issued <= r_issued + 8'd1;
          end
          if (w_accept) begin
            if (w_last) begin
              r_sum       <= w_add;
              r_sum_valid <= 1'b1;
              r_state     <= HOLD;
              r_acc       <= '0;
              r_issued    <= '0;
              r_recv      <= '0;
              r_blk_cnt   <= r_blk_cnt + 16'd1;
            end else begin
              r_acc  <= w_add;
              r_recv <= r_recv + 8'd1;
            end
          end
        end
        HOLD: begin
          if (r_sum_valid && SUM_READY) begin
            r_sum_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign SUM         = r_sum;
  assign SUM_VALID   = r_sum_valid;
  assign BLK_CNT     = r_blk_cnt;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: FIFO read-port model with configurable latency and
// burstiness, block-sum reference model and scoreboard for 24- and 16-bit sums.
module tb_prod_accum;
  localparam int N    = 4;
  localparam int AW   = 24;
  localparam int AW16 = 16;

  logic CLK = 1'b0;
  logic RST;
  logic EMPTY = 1'b1;
  logic VALID;
  logic SUM_READY = 1'b0;
  logic [15:0] FIFO_DOUT;
  logic RD, RD16, SUM_VALID, SUM_VALID16, dbg, dbg16;
  logic [AW-1:0] SUM;
  logic [AW16-1:0] SUM16;
  logic [15:0] BLK_CNT, BLK_CNT16;

  int n_vec = 0;
  int n_err = 0;

  // FIFO model
  logic [15:0] fq[$];
  int lat = 1;
  bit burst = 1'b0;
  bit spur = 1'b0;
  bit phase = 1'b0;
  logic [16:0] st0 = '0;
  logic [16:0] st1 = '0;
  logic [16:0] st_out;
  logic rd_neg = 1'b0;
  int underflow = 0;

  // monitor
  int cyc = 0, rd_cnt = 0, sv_cycles = 0, rd_in_hold = 0, unstable = 0, ctl_diff = 0;
  int first_rd_cyc = -1, sv_rise_cyc = -1;
  logic prev_sv = 1'b0, prev_hs = 1'b0;
  logic [AW-1:0] prev_sum = '0;
  logic [AW-1:0] obs_sum[$];
  logic [AW16-1:0] obs_sum16[$];
  logic [15:0] obs_blk[$];

  // scoreboard
  logic [AW-1:0] exp_q[$];
  logic [AW16-1:0] exp16_q[$];
  logic [15:0] expb_q[$];
  logic [15:0] blk_model = '0;

  always #5 CLK = ~CLK;

  prod_accum #(.BLOCK_LEN(N), .ACC_W(AW)) dut (
    .CLK(CLK), .RST(RST), .EMPTY(EMPTY), .VALID(VALID), .FIFO_DOUT(FIFO_DOUT),
    .RD(RD), .SUM(SUM), .SUM_VALID(SUM_VALID), .SUM_READY(SUM_READY),
    .BLK_CNT(BLK_CNT), .o_state_dbg(dbg)
  );

  prod_accum #(.BLOCK_LEN(N), .ACC_W(AW16)) dut16 (
    .CLK(CLK), .RST(RST), .EMPTY(EMPTY), .VALID(VALID), .FIFO_DOUT(FIFO_DOUT),
    .RD(RD16), .SUM(SUM16), .SUM_VALID(SUM_VALID16), .SUM_READY(SUM_READY),
    .BLK_CNT(BLK_CNT16), .o_state_dbg(dbg16)
  );

  always @(posedge CLK) begin
    #1;
    st1 = st0;
    st0 = '0;
    if (!RST) fq.delete();
    else if (rd_neg) begin
      if (fq.size() == 0) underflow++;
      else st0 = {1'b1, fq.pop_front()};
    end
    phase = ~phase;
    EMPTY = (fq.size() == 0) || (burst && phase);
  end
  assign st_out    = (lat == 2) ? st1 : st0;
  assign VALID     = st_out[16] | spur;
  assign FIFO_DOUT = st_out[16] ? st_out[15:0] : (spur ? 16'hDEAD : 16'h0000);

  always @(negedge CLK) begin
    cyc++;
    rd_neg = RD;
    if (RD) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (SUM_VALID) begin
      sv_cycles++;
      if (!prev_sv && sv_rise_cyc < 0) sv_rise_cyc = cyc;
    end
    if (RD && SUM_VALID) rd_in_hold++;
    if (RD16 !== RD || SUM_VALID16 !== SUM_VALID || dbg16 !== dbg) ctl_diff++;
    if (RST && prev_sv && !prev_hs && (!SUM_VALID || SUM !== prev_sum)) unstable++;
    prev_sv  = SUM_VALID;
    prev_sum = SUM;
    prev_hs  = SUM_VALID && SUM_READY;
    if (RST && SUM_VALID && SUM_READY) begin
      obs_sum.push_back(SUM);
      obs_sum16.push_back(SUM16);
      obs_blk.push_back(BLK_CNT);
    end
  end

  function automatic longint model_sum(input logic [15:0] blk[$], input int w);
    longint mx;
    longint acc;
    mx  = (longint'(1) << w) - 1;
    acc = 0;
    foreach (blk[i]) begin
      acc += longint'(blk[i]);
`ifdef PROD_ACCUM_SAT_EN
      if (acc > mx) acc = mx;
`else
      acc = acc & mx;
`endif
    end
    return acc;
  endfunction

  task automatic push_block(input logic [15:0] blk[$]);
    foreach (blk[i]) fq.push_back(blk[i]);
    exp_q.push_back(AW'(model_sum(blk, AW)));
    exp16_q.push_back(AW16'(model_sum(blk, AW16)));
    blk_model = blk_model + 16'd1;
    expb_q.push_back(blk_model);
  endtask

  task automatic push4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    logic [15:0] q[$];
    q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
    push_block(q);
  endtask

  task automatic clear_mon();
    rd_cnt = 0; sv_cycles = 0; rd_in_hold = 0; unstable = 0; underflow = 0; ctl_diff = 0;
    first_rd_cyc = -1; sv_rise_cyc = -1;
    obs_sum.delete(); obs_sum16.delete(); obs_blk.delete();
    exp_q.delete(); exp16_q.delete(); expb_q.delete();
  endtask

  task automatic apply_reset();
    RST = 1'b0; SUM_READY = 1'b0; spur = 1'b0; burst = 1'b0; lat = 1;
    repeat (3) @(posedge CLK);
    #2;
    clear_mon();
    blk_model = '0;
    RST = 1'b1;
    @(posedge CLK); #2;
  endtask

  task automatic wait_sums(input int n, input int budget);
    int k;
    k = 0;
    while (obs_sum.size() < n && k < budget) begin
      @(posedge CLK); #2;
      k++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; SUM_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    n_vec += 6;
    if (RD !== 1'b0) begin n_err++; $display("FAIL reset_rd got=%b exp=0", RD); end
    if (SUM !== '0) begin n_err++; $display("FAIL reset_sum got=%0h exp=0", SUM); end
    if (SUM_VALID !== 1'b0) begin n_err++; $display("FAIL reset_sv got=%b exp=0", SUM_VALID); end
    if (BLK_CNT !== 16'd0) begin n_err++; $display("FAIL reset_blk got=%0h exp=0", BLK_CNT); end
    if (dbg !== 1'b0) begin n_err++; $display("FAIL reset_state got=%b exp=0", dbg); end
    if (BLK_CNT16 !== 16'd0) begin n_err++; $display("FAIL reset_blk16 got=%0h exp=0", BLK_CNT16); end
    RST = 1'b1;
    clear_mon();
    repeat (3) @(posedge CLK);
    #2;
    n_vec += 2;
    if (RD !== 1'b0) begin n_err++; $display("FAIL idle_rd got=%b exp=0", RD); end
    if (SUM_VALID !== 1'b0) begin n_err++; $display("FAIL idle_sv got=%b exp=0", SUM_VALID); end
  endtask

  task automatic test_basic();
    apply_reset();
    SUM_READY = 1'b1;
    push4(16'd6, 16'd12, 16'd20, 16'd30);
    wait_sums(1, 50);
    repeat (4) @(posedge CLK);
    #2;
    n_vec += 7;
    if (obs_sum.size() !== 1) begin n_err++; $display("FAIL basic_count got=%0d exp=1", obs_sum.size()); end
    if (obs_sum.size() > 0 && obs_sum[0] !== 24'h44) begin n_err++; $display("FAIL basic_sum got=%0h exp=44", obs_sum[0]); end
    if (obs_sum16.size() > 0 && obs_sum16[0] !== 16'h44) begin n_err++; $display("FAIL basic_sum16 got=%0h exp=44", obs_sum16[0]); end
    if (BLK_CNT !== 16'd1) begin n_err++; $display("FAIL basic_blk got=%0d exp=1", BLK_CNT); end
    if (rd_cnt !== 4) begin n_err++; $display("FAIL basic_rd_count got=%0d exp=4", rd_cnt); end
    if (sv_cycles !== 1) begin n_err++; $display("FAIL basic_sv_width got=%0d exp=1", sv_cycles); end
    if (sv_rise_cyc - first_rd_cyc !== N + 1) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", sv_rise_cyc - first_rd_cyc, N + 1); end
  endtask

  task automatic test_backpressure();
    int k, bad;
    logic [AW-1:0] g, e;
    logic [15:0] gb, eb;
    apply_reset();
    SUM_READY = 1'b0;
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    push4(16'd5, 16'd6, 16'd7, 16'd8);
    k = 0;
    while (SUM_VALID !== 1'b1 && k < 50) begin @(posedge CLK); #2; k++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (SUM !== 24'd10 || SUM_VALID !== 1'b1 || RD !== 1'b0 || dbg !== 1'b1) bad++;
    end
    n_vec += 2;
    if (bad !== 0) begin n_err++; $display("FAIL bp_hold bad_cycles got=%0d exp=0", bad); end
    if (rd_cnt !== 4) begin n_err++; $display("FAIL bp_rd_count got=%0d exp=4", rd_cnt); end
    @(posedge CLK); #2;
    SUM_READY = 1'b1;
    wait_sums(2, 60);
    n_vec += 2;
    if (obs_sum.size() !== 2) begin n_err++; $display("FAIL bp_count got=%0d exp=2", obs_sum.size()); end
    if (rd_cnt !== 8) begin n_err++; $display("FAIL bp_rd_total got=%0d exp=8", rd_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); eb = expb_q.pop_front(); void'(exp16_q.pop_front());
      g  = (obs_sum.size() > 0) ? obs_sum.pop_front() : 'x;
      gb = (obs_blk.size() > 0) ? obs_blk.pop_front() : 'x;
      n_vec += 2;
      if (g !== e) begin n_err++; $display("FAIL bp_sum got=%0h exp=%0h", g, e); end
      if (gb !== eb) begin n_err++; $display("FAIL bp_blk got=%0h exp=%0h", gb, eb); end
    end
  endtask

  task automatic test_bursty();
    logic [AW-1:0] g, e;
    logic [AW16-1:0] g16, e16;
    apply_reset();
    lat = 2; burst = 1'b1; SUM_READY = 1'b1;
    spur = 1'b1; @(posedge CLK); #2; spur = 1'b0;
    push4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wait_sums(1, 80);
    repeat (3) @(posedge CLK); #2;
    n_vec += 1;
    if (rd_cnt !== 4) begin n_err++; $display("FAIL burst_rd_count got=%0d exp=4", rd_cnt); end
    spur = 1'b1; @(posedge CLK); #2; spur = 1'b0;
    push4(16'd1, 16'd1, 16'd1, 16'd1);
    wait_sums(2, 80);
    n_vec += 2;
    if (underflow !== 0) begin n_err++; $display("FAIL burst_underflow got=%0d exp=0", underflow); end
    if (obs_sum.size() !== 2) begin n_err++; $display("FAIL burst_count got=%0d exp=2", obs_sum.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); e16 = exp16_q.pop_front(); void'(expb_q.pop_front());
      g   = (obs_sum.size() > 0) ? obs_sum.pop_front() : 'x;
      g16 = (obs_sum16.size() > 0) ? obs_sum16.pop_front() : 'x;
      n_vec += 2;
      if (g !== e) begin n_err++; $display("FAIL burst_sum got=%0h exp=%0h", g, e); end
      if (g16 !== e16) begin n_err++; $display("FAIL burst_sum16 got=%0h exp=%0h", g16, e16); end
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] g, e;
    logic [AW16-1:0] g16, e16;
    apply_reset();
    SUM_READY = 1'b1;
    push4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    push4(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0002);
    wait_sums(2, 60);
    n_vec += 1;
    if (obs_sum.size() !== 2) begin n_err++; $display("FAIL ovf_count got=%0d exp=2", obs_sum.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); e16 = exp16_q.pop_front(); void'(expb_q.pop_front());
      g   = (obs_sum.size() > 0) ? obs_sum.pop_front() : 'x;
      g16 = (obs_sum16.size() > 0) ? obs_sum16.pop_front() : 'x;
      n_vec += 2;
      if (g !== e) begin n_err++; $display("FAIL ovf_sum got=%0h exp=%0h", g, e); end
      if (g16 !== e16) begin n_err++; $display("FAIL ovf_sum16 got=%0h exp=%0h", g16, e16); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [AW-1:0] g, e;
    logic [15:0] gb, eb;
    apply_reset();
    lat = 2; SUM_READY = 1'b1;
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    wait_sums(1, 60);
    clear_mon();
    fq.push_back(16'd9); fq.push_back(16'd9); fq.push_back(16'd7);
    k = 0;
    while (rd_cnt < 2 && k < 40) begin @(posedge CLK); #2; k++; end
    RST = 1'b0;
    #1;
    n_vec += 5;
    if (RD !== 1'b0) begin n_err++; $display("FAIL mid_rst_rd got=%b exp=0", RD); end
    if (SUM !== '0) begin n_err++; $display("FAIL mid_rst_sum got=%0h exp=0", SUM); end
    if (SUM16 !== '0) begin n_err++; $display("FAIL mid_rst_sum16 got=%0h exp=0", SUM16); end
    if (SUM_VALID !== 1'b0) begin n_err++; $display("FAIL mid_rst_sv got=%b exp=0", SUM_VALID); end
    if (BLK_CNT !== 16'd0) begin n_err++; $display("FAIL mid_rst_blk got=%0h exp=0", BLK_CNT); end
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #2;
    clear_mon();
    blk_model = '0;
    push4(16'd1, 16'd1, 16'd1, 16'd1);
    wait_sums(1, 60);
    n_vec += 1;
    if (obs_sum.size() !== 1) begin n_err++; $display("FAIL mid_count got=%0d exp=1", obs_sum.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); eb = expb_q.pop_front(); void'(exp16_q.pop_front());
      g  = (obs_sum.size() > 0) ? obs_sum.pop_front() : 'x;
      gb = (obs_blk.size() > 0) ? obs_blk.pop_front() : 'x;
      n_vec += 2;
      if (g !== e) begin n_err++; $display("FAIL mid_sum got=%0h exp=%0h", g, e); end
      if (gb !== eb) begin n_err++; $display("FAIL mid_blk got=%0h exp=%0h", gb, eb); end
    end
  endtask

  task automatic test_random();
    int k, nb, mode;
    logic [15:0] q[$];
    logic [AW-1:0] g, e;
    logic [AW16-1:0] g16, e16;
    logic [15:0] gb, eb;
    apply_reset();
    lat = $urandom_range(1, 2);
    burst = 1'($urandom_range(0, 1));
    nb = 24;
    for (int b = 0; b < nb; b++) begin
      q.delete();
      mode = $urandom_range(0, 2);
      for (int w = 0; w < N; w++) begin
        if (mode == 0) q.push_back(16'($urandom_range(0, 255)));
        else if (mode == 1) q.push_back(16'($urandom_range(0, 65535)));
        else q.push_back(16'($urandom_range(65000, 65535)));
      end
      push_block(q);
    end
    k = 0;
    while (obs_sum.size() < nb && k < 3000) begin
      SUM_READY = 1'($urandom_range(0, 1));
      @(posedge CLK); #2;
      k++;
    end
    n_vec += 6;
    if (obs_sum.size() !== nb) begin n_err++; $display("FAIL rnd_count got=%0d exp=%0d", obs_sum.size(), nb); end
    if (rd_cnt !== nb * N) begin n_err++; $display("FAIL rnd_rd_count got=%0d exp=%0d", rd_cnt, nb * N); end
    if (rd_in_hold !== 0) begin n_err++; $display("FAIL rnd_rd_in_hold got=%0d exp=0", rd_in_hold); end
    if (unstable !== 0) begin n_err++; $display("FAIL rnd_sum_stable got=%0d exp=0", unstable); end
    if (underflow !== 0) begin n_err++; $display("FAIL rnd_underflow got=%0d exp=0", underflow); end
    if (ctl_diff !== 0) begin n_err++; $display("FAIL rnd_ctl_w16 got=%0d exp=0", ctl_diff); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); e16 = exp16_q.pop_front(); eb = expb_q.pop_front();
      g   = (obs_sum.size() > 0) ? obs_sum.pop_front() : 'x;
      g16 = (obs_sum16.size() > 0) ? obs_sum16.pop_front() : 'x;
      gb  = (obs_blk.size() > 0) ? obs_blk.pop_front() : 'x;
      n_vec += 3;
      if (g !== e) begin n_err++; $display("FAIL rnd_sum got=%0h exp=%0h", g, e); end
      if (g16 !== e16) begin n_err++; $display("FAIL rnd_sum16 got=%0h exp=%0h", g16, e16); end
      if (gb !== eb) begin n_err++; $display("FAIL rnd_blk got=%0h exp=%0h", gb, eb); end
    end
  endtask

  task automatic test_blk_wrap();
    logic [15:0] gb, eb;
    apply_reset();
    SUM_READY = 1'b1;
    @(negedge CLK);
    force dut.r_blk_cnt = 16'hFFFE;
    @(negedge CLK);
    release dut.r_blk_cnt;
    blk_model = 16'hFFFE;
    @(posedge CLK); #2;
    push4(16'd0, 16'd0, 16'd0, 16'd0);
    push4(16'd0, 16'd0, 16'd0, 16'd0);
    wait_sums(2, 60);
    repeat (2) @(posedge CLK); #2;
    n_vec += 2;
    if (obs_blk.size() !== 2) begin n_err++; $display("FAIL wrap_count got=%0d exp=2", obs_blk.size()); end
    if (BLK_CNT !== 16'h0000) begin n_err++; $display("FAIL wrap_final got=%0h exp=0", BLK_CNT); end
    while (expb_q.size() > 0) begin
      eb = expb_q.pop_front(); void'(exp_q.pop_front()); void'(exp16_q.pop_front());
      gb = (obs_blk.size() > 0) ? obs_blk.pop_front() : 'x;
      n_vec += 1;
      if (gb !== eb) begin n_err++; $display("FAIL wrap_blk got=%0h exp=%0h", gb, eb); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bursty();
    test_overflow();
    test_reset_mid();
    test_random();
    test_blk_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
